// File: rtl/redirect_pkg.sv
// Shared definitions for the ID-stage redirect/stall unit.
// GPR address width, the hardwired zero register, and mult/div FSM states.
package redirect_pkg;

  localparam int GPR_ADDR_W = 5;

  localparam logic [GPR_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_t;

endpackage

// File: rtl/redirect_port_sel.sv
// One read port: priority match across producer stages, youngest first.
// Returns the forwarded operand and whether the winning producer is not ready.
module redirect_port_sel
  import redirect_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NSTAGE = 3
) (
  input  logic                         rd_en,
  input  logic [GPR_ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]            rf_data,
  input  logic [NSTAGE-1:0]            st_wen,
  input  logic [NSTAGE*GPR_ADDR_W-1:0] st_rw,
  input  logic [NSTAGE-1:0]            st_rdy,
  input  logic [NSTAGE*DATA_W-1:0]     st_data,
  output logic [DATA_W-1:0]            fwd_data,
  output logic                         not_ready
);

  logic found;

  // First matching stage wins; later (older) stages cannot override it.
  always_comb begin
    fwd_data  = rf_data;
    not_ready = 1'b0;
    found     = 1'b0;
    for (int s = 0; s < NSTAGE; s++) begin
      if (!found && rd_en && st_wen[s] &&
          (rd_addr != ZERO_REG) &&
          (st_rw[s*GPR_ADDR_W +: GPR_ADDR_W] == rd_addr)) begin
        found     = 1'b1;
        fwd_data  = st_data[s*DATA_W +: DATA_W];
        not_ready = ~st_rdy[s];
      end
    end
  end

endmodule

// File: rtl/redirect_stall_unit.sv
// ID-stage operand forwarding, load-use interlock and mult/div scoreboard.
// Also counts stalled cycles with a saturating counter.
module redirect_stall_unit
  import redirect_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREAD  = 2,
  parameter int NSTAGE = 3,
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREAD-1:0]             rd_en,
  input  logic [NREAD*GPR_ADDR_W-1:0]  rd_addr,
  input  logic [NREAD*DATA_W-1:0]      rf_data,
  input  logic [NSTAGE-1:0]            st_wen,
  input  logic [NSTAGE*GPR_ADDR_W-1:0] st_rw,
  input  logic [NSTAGE-1:0]            st_rdy,
  input  logic [NSTAGE*DATA_W-1:0]     st_data,
  input  logic                         id_hilo_rd,
  input  logic                         id_md_issue,
  input  logic                         md_start,
  input  logic                         md_cancel,
  output logic [NREAD*DATA_W-1:0]      fwd_data,
  output logic                         stall,
  output logic                         md_busy,
  output logic                         md_done,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int MCW = $clog2(MD_LAT + 1);

  if (NREAD < 1 || NSTAGE < 1 || MD_LAT < 1) begin : g_bad_param
    $fatal(1, "redirect_stall_unit: NREAD, NSTAGE, MD_LAT must be >= 1");
  end

  logic [NREAD-1:0] port_nr;
  logic             gpr_hazard;

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    redirect_port_sel #(
      .DATA_W (DATA_W),
      .NSTAGE (NSTAGE)
    ) u_sel (
      .rd_en     (rd_en[p]),
      .rd_addr   (rd_addr[p*GPR_ADDR_W +: GPR_ADDR_W]),
      .rf_data   (rf_data[p*DATA_W +: DATA_W]),
      .st_wen    (st_wen),
      .st_rw     (st_rw),
      .st_rdy    (st_rdy),
      .st_data   (st_data),
      .fwd_data  (fwd_data[p*DATA_W +: DATA_W]),
      .not_ready (port_nr[p])
    );
  end

  assign gpr_hazard = |port_nr;

  md_state_t      md_state, md_state_nx;
  logic [MCW-1:0] md_cnt, md_cnt_nx;

  // Mult/div state and remaining-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
    end else begin
      md_state <= md_state_nx;
      md_cnt   <= md_cnt_nx;
    end
  end

  // Cancel beats completion and start; a start while busy is dropped.
  always_comb begin
    md_state_nx = md_state;
    md_cnt_nx   = md_cnt;
    md_done     = 1'b0;
    if (md_cancel) begin
      md_state_nx = MD_IDLE;
      md_cnt_nx   = '0;
    end else begin
      unique case (md_state)
        MD_IDLE: begin
          if (md_start) begin
            md_state_nx = MD_BUSY;
            md_cnt_nx   = MCW'(MD_LAT - 1);
          end
        end
        MD_BUSY: begin
          if (md_cnt == '0) begin
            md_state_nx = MD_IDLE;
            md_done     = ~rst;
          end else begin
            md_cnt_nx = md_cnt - 1'b1;
          end
        end
        default: begin
          md_state_nx = MD_IDLE;
          md_cnt_nx   = '0;
        end
      endcase
    end
  end

  assign md_busy = (md_state == MD_BUSY);

  assign stall = gpr_hazard |
                 (md_busy & (id_hilo_rd | id_md_issue));

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_redirect_stall_unit.sv
// Directed bench for redirect_stall_unit, MD_LAT=4, 2 ports, 3 stages.
// Each task drives one scenario and checks against hand-derived values.
module tb_redirect_stall_unit;

  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NS = 3;
  localparam int ML = 4;
  localparam int CW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  rd_en;
  logic [NR*5-1:0] rd_addr;
  logic [NR*DW-1:0] rf_data;
  logic [NS-1:0]  st_wen;
  logic [NS*5-1:0] st_rw;
  logic [NS-1:0]  st_rdy;
  logic [NS*DW-1:0] st_data;
  logic           id_hilo_rd;
  logic           id_md_issue;
  logic           md_start;
  logic           md_cancel;
  logic [NR*DW-1:0] fwd_data;
  logic           stall;
  logic           md_busy;
  logic           md_done;
  logic [CW-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  redirect_stall_unit #(
    .DATA_W (DW),
    .NREAD  (NR),
    .NSTAGE (NS),
    .MD_LAT (ML),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rf_data     (rf_data),
    .st_wen      (st_wen),
    .st_rw       (st_rw),
    .st_rdy      (st_rdy),
    .st_data     (st_data),
    .id_hilo_rd  (id_hilo_rd),
    .id_md_issue (id_md_issue),
    .md_start    (md_start),
    .md_cancel   (md_cancel),
    .fwd_data    (fwd_data),
    .stall       (stall),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rd_en       = '0;
    rd_addr     = '0;
    rf_data     = '0;
    st_wen      = '0;
    st_rw       = '0;
    st_rdy      = '0;
    st_data     = '0;
    id_hilo_rd  = 1'b0;
    id_md_issue = 1'b0;
    md_start    = 1'b0;
    md_cancel   = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (md_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %0b want 0", md_busy);
    end
    checks++;
    if (md_done !== 1'b0) begin
      errors++; $display("FAIL reset_done got %0b want 0", md_done);
    end
    checks++;
    if (stall_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt got %0d want 0", stall_cnt);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall got %0b want 0", stall);
    end
    next_cycle();
  endtask

  task automatic test_youngest_wins();
    clear_inputs();
    rd_en = 2'b11;
    rd_addr[4:0] = 5'd5;
    rd_addr[9:5] = 5'd9;
    rf_data[63:32] = 32'hAAAA_0001;
    st_wen = 3'b011;
    st_rw[4:0] = 5'd5;
    st_rw[9:5] = 5'd5;
    st_rdy = 3'b111;
    st_data[31:0] = 32'h11;
    st_data[63:32] = 32'h22;
    st_data[95:64] = 32'h99;
    @(negedge clk);
    checks++;
    if (fwd_data[31:0] !== 32'h11) begin
      errors++; $display("FAIL yw_ex got %h want 11", fwd_data[31:0]);
    end
    checks++;
    if (fwd_data[63:32] !== 32'hAAAA_0001) begin
      errors++; $display("FAIL yw_rf got %h want aaaa0001", fwd_data[63:32]);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL yw_stall got %0b want 0", stall);
    end
    next_cycle();
    st_wen = 3'b110;
    st_rw[14:10] = 5'd5;
    @(negedge clk);
    checks++;
    if (fwd_data[31:0] !== 32'h22) begin
      errors++; $display("FAIL yw_mem got %h want 22", fwd_data[31:0]);
    end
    next_cycle();
    st_wen = 3'b100;
    rd_en = 2'b10;
    @(negedge clk);
    checks++;
    if (fwd_data[31:0] !== 32'h0) begin
      errors++; $display("FAIL yw_rden got %h want 0", fwd_data[31:0]);
    end
    next_cycle();
    rd_en = 2'b11;
    @(negedge clk);
    checks++;
    if (fwd_data[31:0] !== 32'h99) begin
      errors++; $display("FAIL yw_wb got %h want 99", fwd_data[31:0]);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    logic [CW-1:0] c0;
    clear_inputs();
    rd_en = 2'b10;
    rd_addr[9:5] = 5'd8;
    st_wen = 3'b011;
    st_rw[4:0] = 5'd8;
    st_rw[9:5] = 5'd8;
    st_rdy = 3'b110;
    st_data[63:32] = 32'h33;
    @(negedge clk);
    c0 = stall_cnt;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL lu_stall got %0b want 1", stall);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (stall_cnt !== c0 + 1) begin
      errors++; $display("FAIL lu_cnt1 got %0d want %0d", stall_cnt, c0 + 1);
    end
    next_cycle();
    st_wen = 3'b010;
    st_data[63:32] = 32'h44;
    @(negedge clk);
    checks++;
    if (fwd_data[63:32] !== 32'h44) begin
      errors++; $display("FAIL lu_fwd got %h want 44", fwd_data[63:32]);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL lu_clear got %0b want 0", stall);
    end
    checks++;
    if (stall_cnt !== c0 + 2) begin
      errors++; $display("FAIL lu_cnt2 got %0d want %0d", stall_cnt, c0 + 2);
    end
    next_cycle();
    st_wen = 3'b011;
    st_rdy = 3'b101;
    st_data[31:0] = 32'h55;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || fwd_data[63:32] !== 32'h55) begin
      errors++;
      $display("FAIL lu_older got stall=%0b d=%h want 0 55",
               stall, fwd_data[63:32]);
    end
    next_cycle();
  endtask

  task automatic test_r0();
    clear_inputs();
    rd_en = 2'b11;
    rf_data = {32'hBEEF_0002, 32'hBEEF_0001};
    st_wen = 3'b001;
    st_rdy = 3'b000;
    st_data[31:0] = 32'hDEAD;
    @(negedge clk);
    checks++;
    if (fwd_data !== {32'hBEEF_0002, 32'hBEEF_0001}) begin
      errors++; $display("FAIL r0_fwd got %h want beef0002beef0001", fwd_data);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL r0_stall got %0b want 0", stall);
    end
    next_cycle();
  endtask

  task automatic test_md_timing();
    logic [CW-1:0] c0;
    clear_inputs();
    md_start = 1'b1;
    @(negedge clk);
    c0 = stall_cnt;
    checks++;
    if (md_busy !== 1'b0) begin
      errors++; $display("FAIL md_t0 got busy=%0b want 0", md_busy);
    end
    next_cycle();
    md_start = 1'b0;
    id_hilo_rd = 1'b1;
    for (int k = 1; k <= ML; k++) begin
      @(negedge clk);
      checks++;
      if (md_busy !== 1'b1 || stall !== 1'b1 ||
          md_done !== (k == ML)) begin
        errors++;
        $display("FAIL md_t%0d got busy=%0b stall=%0b done=%0b want 1 1 %0b",
                 k, md_busy, stall, md_done, k == ML);
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (md_busy !== 1'b0 || md_done !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL md_after got busy=%0b done=%0b stall=%0b want 0 0 0",
               md_busy, md_done, stall);
    end
    checks++;
    if (stall_cnt !== c0 + ML) begin
      errors++; $display("FAIL md_cnt got %0d want %0d", stall_cnt, c0 + ML);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    md_start = 1'b1;
    next_cycle();
    md_start = 1'b0;
    id_md_issue = 1'b1;
    for (int k = 1; k <= ML; k++) begin
      md_start = (k == 2);
      @(negedge clk);
      checks++;
      if (md_busy !== 1'b1 || stall !== 1'b1 ||
          md_done !== (k == ML)) begin
        errors++;
        $display("FAIL b2b_t%0d got busy=%0b stall=%0b done=%0b want 1 1 %0b",
                 k, md_busy, stall, md_done, k == ML);
      end
      next_cycle();
    end
    md_start = 1'b1;
    @(negedge clk);
    checks++;
    if (md_busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got busy=%0b want 0", md_busy);
    end
    next_cycle();
    md_start = 1'b0;
    @(negedge clk);
    checks++;
    if (md_busy !== 1'b1) begin
      errors++; $display("FAIL b2b_restart got busy=%0b want 1", md_busy);
    end
    md_cancel = 1'b1;
    next_cycle();
    md_cancel = 1'b0;
  endtask

  task automatic test_cancel();
    clear_inputs();
    md_start = 1'b1;
    next_cycle();
    md_start = 1'b0;
    next_cycle();
    md_cancel = 1'b1;
    @(negedge clk);
    checks++;
    if (md_busy !== 1'b1 || md_done !== 1'b0) begin
      errors++;
      $display("FAIL cn_c2 got busy=%0b done=%0b want 1 0", md_busy, md_done);
    end
    next_cycle();
    md_cancel = 1'b0;
    for (int k = 3; k < 3 + ML + 1; k++) begin
      @(negedge clk);
      checks++;
      if (md_busy !== 1'b0 || md_done !== 1'b0) begin
        errors++;
        $display("FAIL cn_c%0d got busy=%0b done=%0b want 0 0",
                 k, md_busy, md_done);
      end
      next_cycle();
    end
    md_start = 1'b1;
    md_cancel = 1'b1;
    next_cycle();
    md_start = 1'b0;
    md_cancel = 1'b0;
    @(negedge clk);
    checks++;
    if (md_busy !== 1'b0) begin
      errors++; $display("FAIL cn_both got busy=%0b want 0", md_busy);
    end
    next_cycle();
  endtask

  task automatic test_reset_midop();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    rd_en = 2'b01;
    rd_addr[4:0] = 5'd3;
    st_wen = 3'b001;
    st_rw[4:0] = 5'd3;
    for (int k = 0; k < 7; k++) next_cycle();
    clear_inputs();
    md_start = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_cnt !== 32'd7) begin
      errors++; $display("FAIL rm_cnt7 got %0d want 7", stall_cnt);
    end
    next_cycle();
    md_start = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (md_busy !== 1'b1 || md_done !== 1'b0) begin
      errors++;
      $display("FAIL rm_pre got busy=%0b done=%0b want 1 0", md_busy, md_done);
    end
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (md_busy !== 1'b0 || md_done !== 1'b0 ||
          stall !== 1'b0 || stall_cnt !== '0) begin
        errors++;
        $display("FAIL rm_post%0d got busy=%0b done=%0b stall=%0b cnt=%0d want 0",
                 k, md_busy, md_done, stall, stall_cnt);
      end
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_youngest_wins();
    test_load_use();
    test_r0();
    test_md_timing();
    test_back_to_back();
    test_cancel();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
